xnor_correlator: RTL and testbench

XNOR_CORRELATOR -- requirements
Module: xnor_correlator

---
 rtl/xnor_correlator.sv | 140 ++++++++++++++
 tb/tb_xnor_correlator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/xnor_correlator.sv
// xnor_correlator: two-stage XNOR/popcount correlator with an optional
// run counter and lock FSM, built when XNOR_CORRELATOR_LOCK_EN is defined.
// Ports: clk, rst_n (async, active-low); in_valid_i, a_i, b_i sample in;
// clr_i clears run/lock; out_valid_o, xnor_o, score_o, match_o results;
// locked_o lock status; run_cnt_o consecutive-match count (saturating).
module xnor_correlator #(
  parameter int WIDTH    = 8,
  parameter int THRESH   = WIDTH,
  parameter int LOCK_LEN = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  input  logic [WIDTH-1:0]           a_i,
  input  logic [WIDTH-1:0]           b_i,
  input  logic                       clr_i,
  output logic                       out_valid_o,
  output logic [WIDTH-1:0]           xnor_o,
  output logic [$clog2(WIDTH+1)-1:0] score_o,
  output logic                       match_o,
  output logic                       locked_o,
  output logic [7:0]                 run_cnt_o
);

  localparam int SW = $clog2(WIDTH+1);
  localparam logic [SW-1:0] THR = SW'(THRESH);

  logic             valid1_q;
  logic [WIDTH-1:0] x1_q;
  logic [SW-1:0]    pop1;
  logic             match1;

  logic             valid2_q;
  logic [WIDTH-1:0] x2_q;
  logic [SW-1:0]    score_q;
  logic             match_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid1_q <= 1'b0;
      x1_q     <= '0;
    end else begin
      valid1_q <= in_valid_i;
      if (in_valid_i) begin
        x1_q <= ~(a_i ^ b_i);
      end
    end
  end

  always_comb begin
    pop1 = '0;
    for (int i = 0; i < WIDTH; i++) begin
      pop1 = pop1 + SW'(x1_q[i]);
    end
  end

  assign match1 = (pop1 >= THR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid2_q <= 1'b0;
      x2_q     <= '0;
      score_q  <= '0;
      match_q  <= 1'b0;
    end else begin
      valid2_q <= valid1_q;
      if (valid1_q) begin
        x2_q    <= x1_q;
        score_q <= pop1;
        match_q <= match1;
      end
    end
  end

  assign out_valid_o = valid2_q;
  assign xnor_o      = x2_q;
  assign score_o     = score_q;
  assign match_o     = match_q;

`ifdef XNOR_CORRELATOR_LOCK_EN
  typedef enum logic [1:0] {
    SEARCH,
    TRACK,
    LOCK
  } state_e;

  localparam logic [7:0] LOCK_CNT = 8'(LOCK_LEN);

  state_e     state_q;
  state_e     state_d;
  logic [7:0] run_q;
  logic [7:0] run_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      run_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
    end
  end

  // Run/lock advance with the result entering stage 2, so
  // run_cnt_o and locked_o line up with out_valid_o.
  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    if (clr_i) begin
      state_d = SEARCH;
      run_d   = '0;
    end else if (valid1_q) begin
      if (!match1) begin
        state_d = SEARCH;
        run_d   = '0;
      end else begin
        run_d = (run_q == 8'hFF) ? run_q : run_q + 8'd1;
        unique case (state_q)
          SEARCH,
          TRACK:   state_d = (run_d >= LOCK_CNT) ? LOCK : TRACK;
          LOCK:    state_d = LOCK;
          default: state_d = SEARCH;
        endcase
      end
    end
  end

  assign locked_o  = (state_q == LOCK);
  assign run_cnt_o = run_q;
`else
  logic       unused_clr;
  logic [7:0] unused_lock;

  assign unused_clr  = clr_i;
  assign unused_lock = 8'(LOCK_LEN);
  assign locked_o    = 1'b0;
  assign run_cnt_o   = '0;
`endif

endmodule

// File: tb/tb_xnor_correlator.sv
// tb_xnor_correlator: directed bench for xnor_correlator with a
// cycle-level reference model and hand-computed literal checks.
module tb_xnor_correlator;

  localparam int W  = 8;
  localparam int SW = $clog2(W+1);
`ifdef XNOR_CORRELATOR_LOCK_EN
  localparam bit LK = 1'b1;
`else
  localparam bit LK = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         clr = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic [1:0]          ov;
  logic [1:0][W-1:0]   xo;
  logic [1:0][SW-1:0]  sc;
  logic [1:0]          mt;
  logic [1:0]          lk;
  logic [1:0][7:0]     rc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  xnor_correlator #(.WIDTH(W), .THRESH(8), .LOCK_LEN(4)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid),
    .a_i(a), .b_i(b), .clr_i(clr),
    .out_valid_o(ov[0]), .xnor_o(xo[0]), .score_o(sc[0]),
    .match_o(mt[0]), .locked_o(lk[0]), .run_cnt_o(rc[0])
  );

  xnor_correlator #(.WIDTH(W), .THRESH(7), .LOCK_LEN(1)) u7 (
    .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid),
    .a_i(a), .b_i(b), .clr_i(clr),
    .out_valid_o(ov[1]), .xnor_o(xo[1]), .score_o(sc[1]),
    .match_o(mt[1]), .locked_o(lk[1]), .run_cnt_o(rc[1])
  );

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a two-entry delay line of raw samples plus a
  // plain run count; locked simply means run >= lock length.
  logic [W:0]    pipe[$];
  logic          e_ov = 1'b0;
  logic [W-1:0]  e_x = '0;
  logic [SW-1:0] e_sc = '0;
  bit            e_m[2] = '{1'b0, 1'b0};
  int            run[2] = '{0, 0};
  int            thr[2] = '{8, 7};
  int            ll[2]  = '{4, 1};

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe.delete();
      e_ov = 1'b0;
      e_x  = '0;
      e_sc = '0;
      e_m  = '{1'b0, 1'b0};
      run  = '{0, 0};
    end else begin
      pipe.push_back({in_valid, ~(a ^ b)});
      if (pipe.size() > 2) void'(pipe.pop_front());
      e_ov = (pipe.size() == 2) && pipe[0][W];
      if (e_ov) begin
        e_x  = pipe[0][W-1:0];
        e_sc = SW'($countones(e_x));
      end
      for (int k = 0; k < 2; k++) begin
        if (e_ov) e_m[k] = ($countones(e_x) >= thr[k]);
        if (clr) run[k] = 0;
        else if (e_ov) run[k] = e_m[k] ? ((run[k] < 255) ? run[k] + 1 : 255) : 0;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      check("m_ov",   64'(ov[k]), 64'(e_ov));
      check("m_xnor", 64'(xo[k]), 64'(e_x));
      check("m_score",64'(sc[k]), 64'(e_sc));
      check("m_match",64'(mt[k]), 64'(e_m[k]));
      check("m_run",  64'(rc[k]), 64'(LK ? run[k] : 0));
      check("m_lock", 64'(lk[k]), 64'(LK && (run[k] >= ll[k])));
    end
  end

  task automatic put(input bit v, input logic [W-1:0] x,
                     input logic [W-1:0] y, input bit c);
    @(negedge clk);
    in_valid = v;
    a        = x;
    b        = y;
    clr      = c;
  endtask

  logic [W-1:0] ta[8] = '{8'h00, 8'hFF, 8'h80, 8'h7F,
                          8'hC3, 8'h55, 8'hF0, 8'h01};
  logic [W-1:0] tb[8] = '{8'hFF, 8'hFF, 8'h00, 8'h00,
                          8'h3C, 8'hAA, 8'hF1, 8'h01};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 rst_n = 1'b0;
    put(1, 8'hFF, 8'h00, 0);
    put(1, 8'hFF, 8'h00, 0);
    put(1, 8'hFF, 8'h00, 0);
    check("rst_ov",   64'(ov[0]), 64'(0));
    check("rst_xnor", 64'(xo[0]), 64'(0));
    @(negedge clk) rst_n = 1'b1;
    put(0, 8'h00, 8'h00, 0);
    check("lat1_ov", 64'(ov[0]), 64'(0));
    put(0, 8'h00, 8'h00, 0);
    check("lat2_ov",    64'(ov[0]), 64'(1));
    check("lat2_xnor",  64'(xo[0]), 64'(8'h00));
    check("lat2_score", 64'(sc[0]), 64'(0));
    check("lat2_match", 64'(mt[0]), 64'(0));

    put(1, 8'hA5, 8'hA4, 0);
    check("hold_ov",   64'(ov[0]), 64'(0));
    check("hold_xnor", 64'(xo[0]), 64'(8'h00));
    put(0, 8'h00, 8'h00, 0);
    put(0, 8'h00, 8'h00, 0);
    check("a5_xnor",   64'(xo[0]), 64'(8'hFE));
    check("a5_score",  64'(sc[0]), 64'(7));
    check("a5_m8",     64'(mt[0]), 64'(0));
    check("a5_m7",     64'(mt[1]), 64'(1));
    check("a5_lock1",  64'(lk[1]), 64'(LK));
    check("a5_run1",   64'(rc[1]), 64'(LK ? 1 : 0));

    put(1, 8'h3C, 8'h3C, 0);
    put(1, 8'hC3, 8'hC3, 0);
    put(0, 8'h00, 8'h00, 0);
    check("run1",   64'(rc[0]), 64'(LK ? 1 : 0));
    check("lock1",  64'(lk[0]), 64'(0));
    put(1, 8'h5A, 8'h5A, 0);
    put(1, 8'h0F, 8'h0F, 0);
    check("gap_ov",  64'(ov[0]), 64'(0));
    check("gap_run", 64'(rc[0]), 64'(LK ? 2 : 0));
    put(1, 8'hF0, 8'hF0, 0);
    check("run3",  64'(rc[0]), 64'(LK ? 3 : 0));
    check("lock3", 64'(lk[0]), 64'(0));
    put(1, 8'h12, 8'h34, 0);
    check("run4",   64'(rc[0]), 64'(LK ? 4 : 0));
    check("lock4",  64'(lk[0]), 64'(LK));
    check("score4", 64'(sc[0]), 64'(8));
    put(0, 8'h00, 8'h00, 0);
    check("run5",  64'(rc[0]), 64'(LK ? 5 : 0));
    check("lock5", 64'(lk[0]), 64'(LK));
    put(0, 8'h00, 8'h00, 0);
    check("miss_run",   64'(rc[0]), 64'(0));
    check("miss_lock",  64'(lk[0]), 64'(0));
    check("miss_xnor",  64'(xo[0]), 64'(8'hD9));
    check("miss_score", 64'(sc[0]), 64'(5));

    for (int i = 0; i < 8; i++) begin
      put(1, ta[i], tb[i], 0);
      if (i % 3 == 2) put(0, 8'h00, 8'h00, 0);
    end
    put(0, 8'h00, 8'h00, 0);
    put(0, 8'h00, 8'h00, 0);

    repeat (300) put(1, 8'hAA, 8'hAA, 0);
    put(1, 8'hAA, 8'hAA, 0);
    check("sat_run",  64'(rc[0]), 64'(LK ? 255 : 0));
    check("sat_lock", 64'(lk[0]), 64'(LK));
    put(1, 8'hAA, 8'hAA, 1);
    put(0, 8'h00, 8'h00, 0);
    check("clr_ov",    64'(ov[0]), 64'(1));
    check("clr_score", 64'(sc[0]), 64'(8));
    check("clr_lock",  64'(lk[0]), 64'(0));
    check("clr_run",   64'(rc[0]), 64'(0));
    check("clr_lock7", 64'(lk[1]), 64'(0));
    put(0, 8'h00, 8'h00, 0);
    check("post_run",   64'(rc[0]), 64'(LK ? 1 : 0));
    check("post_lock7", 64'(lk[1]), 64'(LK));

    put(1, 8'h11, 8'h22, 0);
    put(1, 8'h33, 8'h33, 0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ov",    64'(ov[0]), 64'(0));
    check("arst_xnor",  64'(xo[0]), 64'(0));
    check("arst_score", 64'(sc[0]), 64'(0));
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b0;
    put(0, 8'h00, 8'h00, 0);
    check("flush_ov1", 64'(ov[0]), 64'(0));
    put(0, 8'h00, 8'h00, 0);
    check("flush_ov2", 64'(ov[0]), 64'(0));
    check("flush_x",   64'(xo[0]), 64'(0));
    put(1, 8'hFF, 8'hFF, 0);
    put(0, 8'h00, 8'h00, 0);
    put(0, 8'h00, 8'h00, 0);
    check("full_xnor",  64'(xo[0]), 64'(8'hFF));
    check("full_score", 64'(sc[0]), 64'(8));
    check("full_match", 64'(mt[0]), 64'(1));
    put(0, 8'h00, 8'h00, 0);
    put(0, 8'h00, 8'h00, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
